zx_ps2_keyboard: RTL and testbench
==================================

Name: zx_ps2_keyboard

Overview:
PS/2 keyboard front end for the ZX Spectrum core. It receives PS/2 set-2 frames, decodes make and break codes into a 40-key active-low Spectrum matrix (8 half-rows x 5 columns), and presents the 5 column bits for the half-rows selected by the CPU high address byte. It sits directly upstream of the port-FE I/O block, which places keys[4:0] on D4..D0 during an IN from port FE.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples required before the filtered ps2_clk changes level.
TIMEOUT_CYCLES, 27000, clk cycles without a ps2_clk falling edge before a partial frame is aborted (1 ms at 27 MHz).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
ps2_clk  input  1  PS/2 clock from the keyboard (open-collector, idle high)
ps2_data  input  1  PS/2 data from the keyboard
addr_hi  input  8  CPU address bits A15..A8; a 0 in bit r selects half-row r
keys  output  5  active-low column bits D4..D0 for the selected half-rows
matrix  output  40  full key state, active-low; bit r*5+c is row r, column c
scan_code  output  8  last valid received byte
scan_valid  output  1  one-cycle pulse: scan_code updated
frame_err  output  1  one-cycle pulse: frame rejected or timed out

Behaviour:
- Reset (clk, reset asynchronous active-low):
  - matrix = all 1; scan_code = 8'h00; scan_valid = 0; frame_err = 0.
  - FSM = IDLE; break and extended flags cleared; filtered clock = 1; timeout counter = 0.
  - Reset mid-frame discards the partial frame.
- Input conditioning:
  - 2-FF synchroniser on ps2_clk and ps2_data.
  - Filtered clock toggles only after FILTER_LEN equal samples.
  - A 1->0 transition of the filtered clock (fall) samples the synchronised data.
- Frame FSM, advanced on each fall:
  - IDLE: data=0 -> DATA, bit count = 0; data=1 -> stay in IDLE, no error.
  - DATA: shift data in LSB first; after bit 7 -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: accepted only if data=1 and the total count of ones in the 8 data bits plus parity is odd.
    - Accepted: scan_code <= byte; scan_valid pulses one cycle.
    - Rejected: frame_err pulses one cycle; scan_code is unchanged.
    - Either way -> IDLE.
  - Timeout: in any state other than IDLE, TIMEOUT_CYCLES without a fall -> IDLE, frame_err pulse. The counter clears on every fall.
- Decoder (registered): matrix reflects a byte 1 clk after its scan_valid pulse.
  - F0: set break flag.
  - E0: set extended flag.
  - AA, FA, EE, FE: ignored; flags unchanged.
  - 00 or FF (keyboard overrun): matrix = all 1, both flags cleared.
  - Any other byte: if mapped, matrix bit <= break flag (make = 0, break = 1). Clear both flags, whether mapped or not.
  - Extended flag set: only 14 (SS) and 5A (ENTER) are mapped; every other code is ignored.
- Map, listed as row r (selected by address bit A(8+r)): column 0..4.
  - r0: CS=12 or 59, Z=1A, X=22, C=21, V=2A
  - r1: A=1C, S=1B, D=23, F=2B, G=34
  - r2: Q=15, W=1D, E=24, R=2D, T=2C
  - r3: 1=16, 2=1E, 3=26, 4=25, 5=2E
  - r4: 0=45, 9=46, 8=3E, 7=3D, 6=36
  - r5: P=4D, O=44, I=43, U=3C, Y=35
  - r6: ENTER=5A, L=4B, K=42, J=3B, H=33
  - r7: SPACE=29, SS=14, M=3A, N=31, B=32
- Shared keys: left and right shift share CS; ctrl and E0 14 share SS. For a shared key, the last make or break event wins.
- keys output:
  - Combinational, zero latency: keys[c] = AND over all r with addr_hi[r]=0 of matrix[r*5+c].
  - addr_hi = FF -> keys = 5'b11111.
  - Multiple zero bits in addr_hi AND their rows together.
- Simultaneous events: a fall during the same cycle the timeout expires counts as a fall; the timeout is not taken.
- Receive only: no host-to-device transmission; ps2 lines are never driven.

Test Plan:
- Frame 1C with correct parity -> scan_valid pulse, scan_code=1C; with addr_hi=FD, keys=11110; with addr_hi=FE, keys=11111.
- Then F0, 1C -> two scan_valid pulses; with addr_hi=FD, keys=11111; matrix all 1.
- Make 12 then 3A; with addr_hi=7E (rows 0 and 7 selected) -> keys=11010; after F0 12, keys=11011.
- Frame 5A with a parity error -> frame_err pulse, no scan_valid, scan_code unchanged; with addr_hi=BF, keys=11111.
- Timeout and glitch:
  - Start bit + 3 data bits, then the line goes idle -> frame_err exactly TIMEOUT_CYCLES after the last fall.
  - Next frame 29 -> with addr_hi=7F, keys=11110.
  - A 3-cycle ps2_clk glitch (shorter than FILTER_LEN) causes no bit to be sampled.
- E0 5A -> with addr_hi=BF, keys=11110; E0 F0 5A -> 11111.
- Reset asserted after 4 data bits of a frame -> all outputs at their reset values immediately; the following full frame 16 decodes (addr_hi=F7 -> keys=11110).

Source files
------------

// File: rtl/zx_ps2_keyboard.sv
// PS/2 set-2 keyboard receiver and ZX Spectrum 8x5 key matrix decoder.
// Frames are taken from a debounced PS/2 clock. Valid bytes drive make/break
// updates of an active-low 40-key matrix. The matrix is read back through the
// CPU high address byte, as seen on port FE.
module zx_ps2_keyboard #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [7:0]  addr_hi,
  output logic [4:0]  keys,
  output logic [39:0] matrix,
  output logic [7:0]  scan_code,
  output logic        scan_valid,
  output logic        frame_err
);

  localparam int FL_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic            r_flt_clk;
  logic [FL_W-1:0] r_flt_cnt;
  logic [TO_W-1:0] r_to_cnt;
  state_t          r_state, w_state_nxt;
  logic [7:0]      r_shift;
  logic [2:0]      r_bit_cnt;
  logic            r_parity;
  logic [7:0]      r_scan_code;
  logic            r_scan_valid, r_frame_err;
  logic [39:0]     r_matrix;
  logic            r_brk, r_ext;
  logic            w_fall, w_timeout, w_accept, w_reject, w_key_hit;
  logic [5:0]      w_key_idx;
  logic [4:0]      w_keys;

  // Set-2 code to matrix index (row*5+col); bit 6 flags a mapped key.
  function automatic logic [6:0] map_key(input logic [7:0] code, input logic ext);
    logic [6:0] m;
    m = 7'd0;
    if (ext) begin
      case (code)
        8'h14: m = {1'b1, 6'd36};
        8'h5A: m = {1'b1, 6'd30};
        default: m = 7'd0;
      endcase
    end else begin
      case (code)
        8'h12, 8'h59: m = {1'b1, 6'd0};
        8'h1A: m = {1'b1, 6'd1};   8'h22: m = {1'b1, 6'd2};   8'h21: m = {1'b1, 6'd3};
        8'h2A: m = {1'b1, 6'd4};   8'h1C: m = {1'b1, 6'd5};   8'h1B: m = {1'b1, 6'd6};
        8'h23: m = {1'b1, 6'd7};   8'h2B: m = {1'b1, 6'd8};   8'h34: m = {1'b1, 6'd9};
        8'h15: m = {1'b1, 6'd10};  8'h1D: m = {1'b1, 6'd11};  8'h24: m = {1'b1, 6'd12};
        8'h2D: m = {1'b1, 6'd13};  8'h2C: m = {1'b1, 6'd14};  8'h16: m = {1'b1, 6'd15};
        8'h1E: m = {1'b1, 6'd16};  8'h26: m = {1'b1, 6'd17};  8'h25: m = {1'b1, 6'd18};
        8'h2E: m = {1'b1, 6'd19};  8'h45: m = {1'b1, 6'd20};  8'h46: m = {1'b1, 6'd21};
        8'h3E: m = {1'b1, 6'd22};  8'h3D: m = {1'b1, 6'd23};  8'h36: m = {1'b1, 6'd24};
        8'h4D: m = {1'b1, 6'd25};  8'h44: m = {1'b1, 6'd26};  8'h43: m = {1'b1, 6'd27};
        8'h3C: m = {1'b1, 6'd28};  8'h35: m = {1'b1, 6'd29};  8'h5A: m = {1'b1, 6'd30};
        8'h4B: m = {1'b1, 6'd31};  8'h42: m = {1'b1, 6'd32};  8'h3B: m = {1'b1, 6'd33};
        8'h33: m = {1'b1, 6'd34};  8'h29: m = {1'b1, 6'd35};  8'h14: m = {1'b1, 6'd36};
        8'h3A: m = {1'b1, 6'd37};  8'h31: m = {1'b1, 6'd38};  8'h32: m = {1'b1, 6'd39};
        default: m = 7'd0;
      endcase
    end
    return m;
  endfunction

  // Two-flop synchronisers; lines idle high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_s1 <= 1'b1; r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1; r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;  r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data; r_dat_s2 <= r_dat_s1;
    end
  end

  // Glitch filter: the level flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flt_clk <= 1'b1;
      r_flt_cnt <= '0;
    end else if (r_clk_s2 == r_flt_clk) begin
      r_flt_cnt <= '0;
    end else if (r_flt_cnt == FL_W'(FILTER_LEN - 1)) begin
      r_flt_clk <= ~r_flt_clk;
      r_flt_cnt <= '0;
    end else begin
      r_flt_cnt <= r_flt_cnt + 1'b1;
    end
  end

  assign w_fall = r_flt_clk & ~r_clk_s2 & (r_flt_cnt == FL_W'(FILTER_LEN - 1));

  // Frame state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: a fall outranks an expiring timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    if (w_fall) begin
      case (r_state)
        S_IDLE:   if (!r_dat_s2) w_state_nxt = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end else if (r_state != S_IDLE && r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
      w_state_nxt = S_IDLE;
      w_timeout   = 1'b1;
    end
  end

  // Frame verdict at the stop bit: stop must be 1 and data+parity odd.
  always_comb begin
    w_accept = 1'b0;
    w_reject = w_timeout;
    if (w_fall && r_state == S_STOP) begin
      if (r_dat_s2 && (^{r_shift, r_parity})) w_accept = 1'b1;
      else                                    w_reject = 1'b1;
    end
  end

  // Bit shifter, bit counter and parity capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else if (w_fall) begin
      if (r_state == S_IDLE) r_bit_cnt <= '0;
      if (r_state == S_DATA) begin
        r_shift   <= {r_dat_s2, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (r_state == S_PARITY) r_parity <= r_dat_s2;
    end
  end

  // Inactivity counter: runs only inside a frame, cleared by every fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                      r_to_cnt <= '0;
    else if (w_fall || w_timeout || r_state == S_IDLE) r_to_cnt <= '0;
    else                                             r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Received byte and one-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scan_code  <= 8'h00;
      r_scan_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_scan_valid <= w_accept;
      r_frame_err  <= w_reject;
      if (w_accept) r_scan_code <= r_shift;
    end
  end

  assign {w_key_hit, w_key_idx} = map_key(r_scan_code, r_ext);

  // Make/break decoder applied the cycle after each accepted byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_matrix <= '1;
      r_brk    <= 1'b0;
      r_ext    <= 1'b0;
    end else if (r_scan_valid) begin
      case (r_scan_code)
        8'hF0: r_brk <= 1'b1;
        8'hE0: r_ext <= 1'b1;
        8'hAA, 8'hFA, 8'hEE, 8'hFE: begin end
        8'h00, 8'hFF: begin
          r_matrix <= '1;
          r_brk    <= 1'b0;
          r_ext    <= 1'b0;
        end
        default: begin
          if (w_key_hit) r_matrix[w_key_idx] <= r_brk;
          r_brk <= 1'b0;
          r_ext <= 1'b0;
        end
      endcase
    end
  end

  // Port-FE read: AND together every half-row whose address bit is low.
  always_comb begin
    w_keys = 5'b11111;
    for (int r = 0; r < 8; r++) begin
      if (!addr_hi[r]) w_keys = w_keys & r_matrix[r*5 +: 5];
    end
  end

  assign keys       = w_keys;
  assign matrix     = r_matrix;
  assign scan_code  = r_scan_code;
  assign scan_valid = r_scan_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_zx_ps2_keyboard.sv
// Bench for zx_ps2_keyboard: directed scenarios plus random frames, checked
// every cycle against a key-table model of the Spectrum matrix.
module tb_zx_ps2_keyboard;

  localparam int F    = 8;
  localparam int T    = 2000;
  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        reset, ps2_clk, ps2_data;
  logic [7:0]  addr_hi, dir_addr, rnd_addr;
  logic        rand_addr;
  logic [4:0]  keys;
  logic [39:0] matrix;
  logic [7:0]  scan_code;
  logic        scan_valid, frame_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_low = 0;
  bit mon_en   = 1'b0;

  // Model state
  logic [39:0] mm;
  bit          brk, ext;
  logic [7:0]  model_sc;
  int          exp_q[$];

  int tab[8][5] = '{
    '{'h12, 'h1A, 'h22, 'h21, 'h2A},
    '{'h1C, 'h1B, 'h23, 'h2B, 'h34},
    '{'h15, 'h1D, 'h24, 'h2D, 'h2C},
    '{'h16, 'h1E, 'h26, 'h25, 'h2E},
    '{'h45, 'h46, 'h3E, 'h3D, 'h36},
    '{'h4D, 'h44, 'h43, 'h3C, 'h35},
    '{'h5A, 'h4B, 'h42, 'h3B, 'h33},
    '{'h29, 'h14, 'h3A, 'h31, 'h32}
  };

  zx_ps2_keyboard #(.FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .addr_hi(addr_hi), .keys(keys), .matrix(matrix), .scan_code(scan_code),
    .scan_valid(scan_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign addr_hi = rand_addr ? rnd_addr : dir_addr;

  initial begin
    rnd_addr = 8'hFF;
    forever begin
      @(posedge clk);
      #1 rnd_addr = 8'($urandom);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int lookup(input int code, input bit e);
    if (e) return (code == 'h14) ? 36 : (code == 'h5A) ? 30 : -1;
    if (code == 'h59) return 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (tab[r][c] == code) return r*5 + c;
    return -1;
  endfunction

  function automatic logic [4:0] exp_keys(input logic [39:0] m, input logic [7:0] a);
    logic [4:0] k = 5'b11111;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!a[r] && !m[r*5 + c]) k[c] = 1'b0;
    return k;
  endfunction

  task automatic model_byte(input int b);
    int idx;
    if (b == 'hF0) brk = 1;
    else if (b == 'hE0) ext = 1;
    else if (b == 'hAA || b == 'hFA || b == 'hEE || b == 'hFE) begin end
    else if (b == 'h00 || b == 'hFF) begin mm = '1; brk = 0; ext = 0; end
    else begin
      idx = lookup(b, ext);
      if (idx >= 0) mm[idx] = brk;
      brk = 0; ext = 0;
    end
  endtask

  // Per-cycle comparison against the model; model advances after the check.
  always @(negedge clk) begin
    int e;
    if (mon_en && reset) begin
      chk("matrix", matrix, mm);
      chk("keys", keys, exp_keys(mm, addr_hi));
      if (scan_valid) begin
        if (exp_q.size() == 0) chk("scan_valid_unexpected", scan_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("scan_code_on_valid", scan_code, e);
          if (e >= 0) begin model_byte(e); model_sc = 8'(e); end
        end
      end
      if (frame_err) begin
        if (exp_q.size() == 0) chk("frame_err_unexpected", frame_err, 0);
        else begin
          e = exp_q.pop_front();
          chk("frame_err_kind", e, -1);
        end
      end
      chk("scan_code_hold", scan_code, model_sc);
    end
  end

  task automatic ps2_bit(input logic b);
    @(negedge clk); ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0; last_low = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] code, input bit par_bad, input bit stop_bad, input int nbits);
    logic [10:0] fr;
    fr = {~stop_bad, (~^code) ^ par_bad, code, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
    @(negedge clk); ps2_data = 1'b1;
  endtask

  task automatic do_frame(input logic [7:0] code, input bit par_bad, input bit stop_bad);
    exp_q.push_back((par_bad || stop_bad) ? -1 : int'(code));
    send_bits(code, par_bad, stop_bad, 11);
    repeat (4) @(negedge clk);
  endtask

  task automatic keys_at(input string name, input logic [7:0] a, input logic [4:0] exp);
    @(negedge clk); dir_addr = a;
    #1 chk(name, keys, exp);
  endtask

  initial begin
    int got;
    logic [7:0] code;
    int sel;
    reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; dir_addr = 8'hFF; rand_addr = 1'b0;
    mm = '1; brk = 0; ext = 0; model_sc = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_matrix", matrix, {40{1'b1}});
    chk("rst_scan_code", scan_code, 8'h00);
    chk("rst_scan_valid", scan_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_keys", keys, 5'b11111);
    @(posedge clk); #2 reset = 1'b1; mon_en = 1'b1;
    repeat (5) @(negedge clk);

    // A make and break
    do_frame(8'h1C, 0, 0);
    chk("a_scan_code", scan_code, 8'h1C);
    keys_at("a_row1", 8'hFD, 5'b11110);
    keys_at("a_row0", 8'hFE, 5'b11111);
    do_frame(8'hF0, 0, 0);
    do_frame(8'h1C, 0, 0);
    keys_at("a_break", 8'hFD, 5'b11111);
    chk("a_break_matrix", matrix, {40{1'b1}});

    // CS + M across two rows, then release
    do_frame(8'h12, 0, 0);
    do_frame(8'h3A, 0, 0);
    keys_at("cs_m", 8'h7E, 5'b11010);
    do_frame(8'hF0, 0, 0);
    do_frame(8'h12, 0, 0);
    keys_at("m_only", 8'h7E, 5'b11011);
    do_frame(8'hF0, 0, 0);
    do_frame(8'h3A, 0, 0);

    // Parity error
    do_frame(8'h5A, 1, 0);
    chk("perr_scan_code", scan_code, 8'h3A);
    keys_at("perr_keys", 8'hBF, 5'b11111);

    // Timeout after start + 3 data bits
    exp_q.push_back(-1);
    send_bits(8'h05, 0, 0, 4);
    got = -1;
    for (int i = 0; i < T + 200; i++) begin
      @(negedge clk);
      if (frame_err) begin got = cyc; break; end
    end
    chk("timeout_cycle", got, last_low + F + 2 + T);
    @(negedge clk);
    chk("timeout_pulse_width", frame_err, 1'b0);

    // Short glitch with data low must not start a frame
    @(negedge clk); ps2_data = 1'b0; ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (30) @(negedge clk);
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    do_frame(8'h29, 0, 0);
    keys_at("space", 8'h7F, 5'b11110);

    // Extended ENTER
    do_frame(8'hE0, 0, 0);
    do_frame(8'h5A, 0, 0);
    keys_at("ext_enter", 8'hBF, 5'b11110);
    do_frame(8'hE0, 0, 0);
    do_frame(8'hF0, 0, 0);
    do_frame(8'h5A, 0, 0);
    keys_at("ext_enter_brk", 8'hBF, 5'b11111);

    // Reset in the middle of a frame
    send_bits(8'h33, 0, 0, 5);
    @(posedge clk); #2 reset = 1'b0;
    mm = '1; brk = 0; ext = 0; model_sc = 8'h00; exp_q.delete();
    #1;
    chk("midrst_matrix", matrix, {40{1'b1}});
    chk("midrst_scan_code", scan_code, 8'h00);
    chk("midrst_scan_valid", scan_valid, 1'b0);
    chk("midrst_frame_err", frame_err, 1'b0);
    @(posedge clk); #2 reset = 1'b1;
    repeat (5) @(negedge clk);
    do_frame(8'h16, 0, 0);
    keys_at("after_rst", 8'hF7, 5'b11110);

    // Random traffic
    rand_addr = 1'b1;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      code = 8'(tab[$urandom_range(0, 7)][$urandom_range(0, 4)]);
      else if (sel == 6) code = 8'hF0;
      else if (sel == 7) code = 8'hE0;
      else begin
        case ($urandom_range(0, 8))
          0: code = 8'hAA; 1: code = 8'hFA; 2: code = 8'hEE; 3: code = 8'hFE;
          4: code = 8'h00; 5: code = 8'h59; 6: code = 8'h14; 7: code = 8'h5A;
          default: code = 8'h76;
        endcase
      end
      do_frame(code, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
    end
    repeat (20) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
